// File: rtl/mips_dcache_if.sv
// Core-side load/store and flush bus of the MIPS data cache.
// Handshake: the core asserts req_valid (or flush) and holds every req_* field stable while stall=1; a request is accepted on the rising edge where req_valid=1 and stall=0.
interface mips_dcache_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        flush;
  logic        flush_done;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, flush,
    input  rdata, stall, flush_done
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, flush,
    output rdata, stall, flush_done
  );
endinterface

// File: rtl/mips_dcache.sv
// Direct-mapped, write-back, write-allocate data cache with one-word lines,
// a stall-based miss engine, dirty-victim writeback and a full flush sequence.
module mips_dcache #(
  parameter int NUM_LINES   = 8,
  parameter int MEM_LATENCY = 4
) (
  input  logic               clk,
  input  logic               rst_b,
  mips_dcache_if.slave       core,
  output logic [31:0]        mem_addr,
  output logic [7:0]         mem_data_in  [0:3],
  input  logic [7:0]         mem_data_out [0:3],
  output logic               mem_write_en,
  output logic [2:0]         dbg_state
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - IDX_W;
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WRITEBACK  = 3'd1,
    S_FILL       = 3'd2,
    S_FLUSH_SCAN = 3'd3,
    S_FLUSH_WB   = 3'd4
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   scan_idx, scan_idx_nx;
  logic [29:0]        lat_word;
  logic [NUM_LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0]   tag_q  [NUM_LINES];
  logic [31:0]        data_q [NUM_LINES];

  logic [IDX_W-1:0]   req_idx, lat_idx, wb_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [31:0]        wb_word, fill_word;
  logic               hit, cnt_last, store_hit, miss_start, install, clean_line;

  assign req_idx    = core.req_addr[IDX_W+1:2];
  assign req_tag    = core.req_addr[31:IDX_W+2];
  assign lat_idx    = lat_word[IDX_W-1:0];
  assign hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign cnt_last   = (cnt == LAST_CNT);
  assign wb_idx     = (state == S_FLUSH_WB) ? scan_idx : lat_idx;
  assign wb_word    = data_q[wb_idx];
  assign fill_word  = {mem_data_out[3], mem_data_out[2], mem_data_out[1], mem_data_out[0]};
  assign dbg_state  = state;

  // A pending flush takes priority over any request presented in the same cycle.
  assign store_hit  = (state == S_IDLE) && !core.flush && core.req_valid && core.req_write && hit;
  assign miss_start = (state == S_IDLE) && !core.flush && core.req_valid && !hit;
  assign install    = (state == S_FILL) && cnt_last;
  assign clean_line = (state == S_FLUSH_WB) && cnt_last;

  always_comb begin
    state_nx        = state;
    scan_idx_nx     = scan_idx;
    core.stall      = 1'b0;
    core.flush_done = 1'b0;
    core.rdata      = '0;
    mem_addr        = '0;
    mem_write_en    = 1'b0;
    case (state)
      S_IDLE: begin
        if (core.flush) begin
          core.stall  = 1'b1;
          scan_idx_nx = '0;
          state_nx    = S_FLUSH_SCAN;
        end else if (core.req_valid) begin
          if (hit) begin
            if (!core.req_write) core.rdata = data_q[req_idx];
          end else begin
            core.stall = 1'b1;
            state_nx   = (valid_q[req_idx] && dirty_q[req_idx]) ? S_WRITEBACK : S_FILL;
          end
        end
      end
      S_WRITEBACK: begin
        core.stall   = 1'b1;
        mem_write_en = 1'b1;
        mem_addr     = {tag_q[lat_idx], lat_idx, 2'b00};
        if (cnt_last) state_nx = S_FILL;
      end
      S_FILL: begin
        core.stall = 1'b1;
        mem_addr   = {lat_word, 2'b00};
        if (cnt_last) state_nx = S_IDLE;
      end
      S_FLUSH_SCAN: begin
        core.stall = 1'b1;
        if (valid_q[scan_idx] && dirty_q[scan_idx]) begin
          state_nx = S_FLUSH_WB;
        end else if (scan_idx == LAST_IDX) begin
          core.flush_done = 1'b1;
          state_nx        = S_IDLE;
        end else begin
          scan_idx_nx = scan_idx + 1'b1;
        end
      end
      S_FLUSH_WB: begin
        core.stall   = 1'b1;
        mem_write_en = 1'b1;
        mem_addr     = {tag_q[scan_idx], scan_idx, 2'b00};
        if (cnt_last) begin
          // A writeback of the final line ends the flush directly, so every line is scanned once.
          if (scan_idx == LAST_IDX) begin
            core.flush_done = 1'b1;
            state_nx        = S_IDLE;
          end else begin
            scan_idx_nx = scan_idx + 1'b1;
            state_nx    = S_FLUSH_SCAN;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
    for (int k = 0; k < 4; k++) begin
      mem_data_in[k] = mem_write_en ? wb_word[8*k +: 8] : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= S_IDLE;
      cnt      <= '0;
      scan_idx <= '0;
      lat_word <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
    end else begin
      state    <= state_nx;
      scan_idx <= scan_idx_nx;
      if (state_nx != state) cnt <= '0;
      else if (state == S_WRITEBACK || state == S_FILL || state == S_FLUSH_WB) cnt <= cnt + 1'b1;
      if (miss_start) lat_word <= core.req_addr[31:2];
      if (store_hit) dirty_q[req_idx] <= 1'b1;
      if (install) begin
        valid_q[lat_idx] <= 1'b1;
        dirty_q[lat_idx] <= 1'b0;
      end
      if (clean_line) dirty_q[scan_idx] <= 1'b0;
    end
  end

  // Line payload needs no reset: valid_q gates every use of it.
  always_ff @(posedge clk) begin
    if (store_hit) data_q[req_idx] <= core.req_wdata;
    if (install) begin
      data_q[lat_idx] <= fill_word;
      tag_q[lat_idx]  <= lat_word[29:IDX_W];
    end
  end
endmodule

// File: tb/tb_mips_dcache.sv
// Self-checking bench for mips_dcache: directed scenarios with literal expectations,
// then randomized loads/stores/flushes checked against a flat-memory and line-tracking model.
module tb_mips_dcache;
  localparam int N     = 8;
  localparam int L     = 4;
  localparam int IDX_W = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  mips_dcache_if core();
  logic [31:0] mem_addr;
  logic [7:0]  mem_data_in  [0:3];
  logic [7:0]  mem_data_out [0:3];
  logic        mem_write_en;
  logic [2:0]  dbg_state;

  mips_dcache #(.NUM_LINES(N), .MEM_LATENCY(L)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .core         (core),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .mem_write_en (mem_write_en),
    .dbg_state    (dbg_state)
  );

  // backing memory: 256 words, combinational read, write while strobe is held
  logic [31:0] mem_words [0:255];
  logic [31:0] rd_word, wb_word;
  assign rd_word = mem_words[mem_addr[9:2]];
  assign mem_data_out[0] = rd_word[7:0];
  assign mem_data_out[1] = rd_word[15:8];
  assign mem_data_out[2] = rd_word[23:16];
  assign mem_data_out[3] = rd_word[31:24];
  assign wb_word = {mem_data_in[3], mem_data_in[2], mem_data_in[1], mem_data_in[0]};

  initial begin
    for (int i = 0; i < 256; i++) mem_words[i] = $urandom;
    mem_words[16] = 32'hDEADBEEF;
    forever begin
      @(negedge clk);
      if (mem_write_en) mem_words[mem_addr[9:2]] = wb_word;
    end
  end

  // reference model: what every word should hold, and which lines the cache holds
  logic [31:0] golden [0:255];
  logic        mvalid [N];
  logic        mdirty [N];
  logic [26:0] mtag   [N];

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  int stall_run;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // scoreboard / compare process
  initial begin
    stall_run = 0;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        stall_run = 0;
      end else begin
        if (mem_write_en) begin
          chk("wb_data", wb_word, golden[mem_addr[9:2]]);
          chk("wb_addr_hi", {10'd0, mem_addr[31:10]}, 32'd0);
        end else begin
          chk("lanes_quiet", wb_word, 32'd0);
        end
        if (!core.stall) chk("idle_addr", mem_addr, 32'd0);
        if (core.req_valid) begin
          if (core.stall) begin
            stall_run++;
          end else begin
            if (exp_q.size() == 0) chk("exp_q_empty", 32'd1, 32'd0);
            else chk("stall_cycles", stall_run, exp_q.pop_front());
            if (!core.req_write) chk("load_data", core.rdata, golden[core.req_addr[9:2]]);
            stall_run = 0;
          end
        end
      end
    end
  end

  // observations from the last request / flush
  int          last_stall, wb_cyc, fl_cycles, fl_wb, fl_done;
  logic [31:0] last_rdata, wb_addr, wb_data, fill_addr;

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    int          idx;
    logic [26:0] tag;
    bit          hit, done;
    idx = int'(addr[IDX_W+1:2]);
    tag = addr[31:IDX_W+2];
    hit = mvalid[idx] && (mtag[idx] == tag);
    exp_q.push_back(hit ? 32'd0 : ((mvalid[idx] && mdirty[idx]) ? 32'(1 + 2*L) : 32'(1 + L)));
    core.req_valid = 1'b1;
    core.req_write = wr;
    core.req_addr  = addr;
    core.req_wdata = wdata;
    last_stall = 0; wb_cyc = 0; wb_addr = 0; wb_data = 0; fill_addr = 0; last_rdata = 0;
    done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!core.stall) begin
        done = 1;
        last_rdata = core.rdata;
        break;
      end
      last_stall++;
      if (mem_write_en) begin
        if (wb_cyc == 0) begin
          wb_addr = mem_addr;
          wb_data = wb_word;
        end
        wb_cyc++;
      end else if (mem_addr != 0) begin
        fill_addr = mem_addr;
      end
    end
    if (!done) chk("req_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (!hit) begin
      mvalid[idx] = 1'b1;
      mtag[idx]   = tag;
      mdirty[idx] = 1'b0;
    end
    if (wr) begin
      golden[addr[9:2]] = wdata;
      mdirty[idx] = 1'b1;
    end
    core.req_valid = 1'b0;
  endtask

  task automatic do_flush();
    int d;
    bit seen;
    d = 0;
    for (int i = 0; i < N; i++) if (mvalid[i] && mdirty[i]) d++;
    core.flush = 1'b1;
    fl_cycles = 0; fl_wb = 0; fl_done = 0; seen = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (core.stall) fl_cycles++;
      if (mem_write_en) fl_wb++;
      if (core.flush_done) begin
        fl_done++;
        seen = 1;
        break;
      end
    end
    if (!seen) chk("flush_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    core.flush = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (core.flush_done) fl_done++;
    end
    chk("flush_cycles_model", fl_cycles, 32'(1 + N + L*d));
    chk("flush_wb_model", fl_wb, 32'(L*d));
    chk("flush_done_pulses", fl_done, 32'd1);
    for (int i = 0; i < N; i++) mdirty[i] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    core.req_valid = 1'b0;
    core.req_write = 1'b0;
    core.req_addr  = '0;
    core.req_wdata = '0;
    core.flush     = 1'b0;
    for (int i = 0; i < N; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
      mtag[i]   = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) golden[i] = mem_words[i];

    chk("rst_stall", {31'd0, core.stall}, 32'd0);
    chk("rst_flush_done", {31'd0, core.flush_done}, 32'd0);
    chk("rst_we", {31'd0, mem_write_en}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_lanes", wb_word, 32'd0);
    chk("rst_rdata", core.rdata, 32'd0);
    rst_b = 1'b1;
    @(posedge clk);
    #1;

    // clean miss then hit
    do_req(1'b0, 32'h40, 32'h0);
    chk("t1_stall", last_stall, 32'd5);
    chk("t1_rdata", last_rdata, 32'hDEADBEEF);
    chk("t1_fill_addr", fill_addr, 32'h40);
    chk("t1_no_wb", wb_cyc, 32'd0);

    // store hit, then reload
    do_req(1'b1, 32'h40, 32'h12345678);
    chk("t2_stall", last_stall, 32'd0);
    chk("t2_no_wb", wb_cyc, 32'd0);
    do_req(1'b0, 32'h40, 32'h0);
    chk("t2_rdata", last_rdata, 32'h12345678);

    // dirty victim: writeback of 0x40, then fill from 0x60
    do_req(1'b0, 32'h60, 32'h0);
    chk("t3_stall", last_stall, 32'd9);
    chk("t3_wb_cycles", wb_cyc, 32'd4);
    chk("t3_wb_addr", wb_addr, 32'h40);
    chk("t3_wb_data", wb_data, 32'h12345678);
    chk("t3_fill_addr", fill_addr, 32'h60);

    // store miss allocates the line, then hits
    do_req(1'b1, 32'h84, 32'hCAFEF00D);
    chk("t4_stall", last_stall, 32'd5);
    chk("t4_fill_addr", fill_addr, 32'h84);
    do_req(1'b0, 32'h84, 32'h0);
    chk("t4_rdata", last_rdata, 32'hCAFEF00D);
    do_req(1'b1, 32'h60, 32'h0BADC0DE);
    chk("t4b_stall", last_stall, 32'd0);

    // flush with lines 0 and 1 dirty, then a flush with nothing dirty
    do_flush();
    chk("t5_cycles", fl_cycles, 32'd17);
    chk("t5_wb", fl_wb, 32'd8);
    chk("t5_mem_60", mem_words[8'h18], 32'h0BADC0DE);
    chk("t5_mem_84", mem_words[8'h21], 32'hCAFEF00D);
    chk("t5_mem_40", mem_words[8'h10], 32'h12345678);
    do_flush();
    chk("t6_cycles", fl_cycles, 32'd9);
    chk("t6_wb", fl_wb, 32'd0);

    // reset in the middle of a fill
    core.req_valid = 1'b1;
    core.req_write = 1'b0;
    core.req_addr  = 32'h40;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("t7_pre_stall", {31'd0, core.stall}, 32'd1);
    rst_b = 1'b0;
    core.req_valid = 1'b0;
    #1;
    chk("t7_stall", {31'd0, core.stall}, 32'd0);
    chk("t7_we", {31'd0, mem_write_en}, 32'd0);
    chk("t7_addr", mem_addr, 32'd0);
    for (int i = 0; i < N; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    do_req(1'b0, 32'h40, 32'h0);
    chk("t7_stall_after", last_stall, 32'd5);
    chk("t7_rdata_after", last_rdata, 32'h12345678);

    // randomized traffic
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 24) == 0) begin
        do_flush();
      end else begin
        a = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
        do_req(1'($urandom_range(0, 1)), a, $urandom);
      end
    end

    // memory must hold final state after a closing flush
    do_flush();
    for (int i = 0; i < 64; i++) chk("final_mem", mem_words[i], golden[i]);
    chk("exp_q_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mips_dcache.md
# mips_dcache

Parametrised direct-mapped, write-back, write-allocate data cache between the MIPS core's load/store path and the byte-lane data memory. It replaces single-cycle cache access with a stall-based miss engine: configurable line count, configurable memory latency, dirty-victim writeback and an explicit flush sequence. The core uses flush at halt so that memory holds final state.

## Interface
- NUM_LINES, 8, number of one-word lines; power of two, ≥2; IDX_W = log2(NUM_LINES)
- MEM_LATENCY, 4, cycles each memory access is held (≥1)
- clk  in  1  clock, all state on rising edge
- rst_b  in  1  asynchronous active-low reset
- req_valid  in  1  core load/store request this cycle
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address; [1:0] ignored (word access)
- req_wdata  in  32  store data
- rdata  out  32  load data, valid when req_valid & !req_write & !stall
- stall  out  1  core must hold request and freeze PC
- flush  in  1  level request to write back all dirty lines
- flush_done  out  1  one-cycle pulse at flush completion
- mem_addr  out  32  word-aligned memory address
- mem_data_in  out  8×[0:3]  store lanes to memory; lane 0 = bits 7:0
- mem_data_out  in  8×[0:3]  load lanes from memory; word = {[3],[2],[1],[0]}
- mem_write_en  out  1  memory write strobe

## Operation
- Address split: index = addr[IDX_W+1:2], tag = addr[31:IDX_W+2]. Per line: valid, dirty, tag, 32-bit data.
- Hit = valid[index] & tag match. States: IDLE, WRITEBACK, FILL, FLUSH_SCAN, FLUSH_WB.
- IDLE, flush=1: stall=1, go FLUSH_SCAN with scan index 0 (flush outranks a pending request).
- IDLE, req_valid & hit: load → rdata = line data combinationally, stall=0; store → line data = req_wdata, dirty=1 at edge, stall=0.
- IDLE, req_valid & miss: stall=1; latch req_addr. Victim valid&dirty → WRITEBACK, else → FILL.
- WRITEBACK: mem_addr = {victim tag, index, 2'b00}, mem_data_in = victim data, mem_write_en=1 for MEM_LATENCY cycles; then FILL.
- FILL: mem_addr = latched address, mem_write_en=0 for MEM_LATENCY cycles; on last cycle's edge install mem_data_out, valid=1, dirty=0, tag; return IDLE, where the held request hits (store then sets dirty — write-allocate).
- FLUSH_SCAN: one line per cycle; line valid&dirty → FLUSH_WB (same bus behaviour as WRITEBACK, then dirty=0, valid kept, resume scan at next index). After line NUM_LINES-1 processed: flush_done=1 for that exit cycle, return IDLE.
- Flush still high in IDLE after done starts a new (harmless) flush; core drops flush on flush_done.
- Latency counter: counts 0..MEM_LATENCY-1, cleared on every state entry.
- Outside WRITEBACK/FLUSH_WB: mem_write_en=0, mem_data_in=0. mem_addr=0 in IDLE/FLUSH_SCAN.

## Timing
- Reset (async, immediate): state IDLE, all valid/dirty=0, counters 0; stall=0, flush_done=0, mem_write_en=0, mem_addr=0, mem_data_in=0, rdata=0 when no hit.
- Hit: 0 stall cycles. Clean miss: stall high 1+MEM_LATENCY cycles. Dirty miss: 1+2·MEM_LATENCY.
- Flush: NUM_LINES scan cycles + MEM_LATENCY per dirty line, + entry cycle; stall high throughout including flush_done cycle.
- Core must hold req_* stable while stall=1; cache uses latched address regardless.
- Reset mid-miss or mid-flush: abort, dirty data discarded, mem_write_en drops asynchronously.
- req_valid=0 in IDLE: no state change, stall=0.

## Test plan
- Reset, load 0x40 (NUM_LINES=8, MEM_LATENCY=4), memory returns 0xDEADBEEF -> stall high 5 cycles, mem_addr=0x40, mem_write_en=0; next cycle rdata=0xDEADBEEF, stall=0.
- Store 0x12345678 to 0x40 after above -> no stall, mem_write_en never 1; following load 0x40 returns 0x12345678.
- Load 0x60 (same index 0, new tag) -> stall 9 cycles; first 4 mem_write_en=1, mem_addr=0x40, lanes {0x78,0x56,0x34,0x12}; next 4 mem_addr=0x60, write_en=0.
- Store 0xCAFEF00D to 0x84 (miss, index 1) -> fill from 0x84 then line holds 0xCAFEF00D dirty; load 0x84 hits with that value.
- Lines 0 and 1 dirty, assert flush -> exactly two 4-cycle writebacks (0x60, 0x84), flush_done single pulse after 1+8+8 cycles; second flush -> no writebacks.
- rst_b low during FILL cycle 2 -> stall=0, mem_write_en=0 immediately; load 0x40 after release misses again (1+4 stall).
